vga_sync_gen: RTL and testbench

//   VGA raster timing generator. Consumes a pixel-rate clock-enable derived

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_sync_gen_axis_counter.sv | 36 +++
 rtl/vga_sync_gen.sv | 105 ++++++++++
 tb/tb_vga_sync_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and shared decode helper for the VGA sync generator.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CNT_W    = 10;

   localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   // Half-open window test: lo <= pos < hi.
   function automatic logic in_window(input int unsigned pos,
                                      input int unsigned lo,
                                      input int unsigned hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// Enabled wrap-at-MAX position counter for one raster axis; resets to MAX.
module vga_axis_counter #(
   parameter int unsigned CNT_W = 10,
   parameter int unsigned MAX   = 799
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= MAX_V;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = en && (cnt_q == MAX_V);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters advanced by a pixel enable, with
// registered sync, active-video and line/frame start outputs coherent with the counters.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        SYNC_POL = 1'b0,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs,
   output logic             vs,
   output logic             video_on,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [CNT_W-1:0] h_cur, v_cur;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             h_wrap, v_wrap, v_en;

   logic hs_q, hs_d;
   logic vs_q, vs_d;
   logic video_on_q, video_on_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   assign v_en = pix_en & h_wrap;

   vga_axis_counter #(.CNT_W(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (pix_en),
      .cnt  (h_cur),
      .wrap (h_wrap)
   );

   vga_axis_counter #(.CNT_W(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (v_en),
      .cnt  (v_cur),
      .wrap (v_wrap)
   );

   // Mirror the counters' next values so the decoded outputs land on the same edge.
   always_comb begin
      h_nxt = h_cur;
      v_nxt = v_cur;
      if (pix_en) begin
         h_nxt = h_wrap ? '0 : h_cur + 1'b1;
         if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cur + 1'b1;
         end
      end
      hs_d          = in_window(32'(h_nxt), HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_d          = in_window(32'(v_nxt), VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
      line_start_d  = v_en;
      frame_start_d = v_wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_cnt       = h_cur;
   assign v_cnt       = v_cur;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen: default 640x480 timing plus a
// reduced-raster pair (both sync polarities) for whole-frame checks.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default 800x525 instance
   logic       rst, pix_en;
   logic [9:0] h_cnt, v_cnt;
   logic       hs, vs, video_on, line_start, frame_start;

   // Reduced 25x19 raster: hs at h=18..21, vs at v=14..15, active 16x12
   logic       rst_s, pen_s;
   logic [4:0] sh_cnt, sv_cnt, ph_cnt, pv_cnt;
   logic       s_hs, s_vs, s_vo, s_ls, s_fs;
   logic       p_hs, p_vs, p_vo, p_ls, p_fs;

   int checks   = 0;
   int failures = 0;
   int eh, ev, sh, sv;

   vga_sync_gen u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .hs(hs), .vs(vs), .video_on(video_on), .line_start(line_start),
      .frame_start(frame_start)
   );

   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b0), .CNT_W(5)
   ) u_small (
      .clk(clk), .rst(rst_s), .pix_en(pen_s), .h_cnt(sh_cnt), .v_cnt(sv_cnt),
      .hs(s_hs), .vs(s_vs), .video_on(s_vo), .line_start(s_ls),
      .frame_start(s_fs)
   );

   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b1), .CNT_W(5)
   ) u_small_pol (
      .clk(clk), .rst(rst_s), .pix_en(pen_s), .h_cnt(ph_cnt), .v_cnt(pv_cnt),
      .hs(p_hs), .vs(p_vs), .video_on(p_vo), .line_start(p_ls),
      .frame_start(p_fs)
   );

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic adv();
      if (eh == 799) begin
         eh = 0;
         ev = (ev == 524) ? 0 : ev + 1;
      end else begin
         eh = eh + 1;
      end
   endtask

   task automatic sadv();
      if (sh == 24) begin
         sh = 0;
         sv = (sv == 18) ? 0 : sv + 1;
      end else begin
         sh = sh + 1;
      end
   endtask

   task automatic pix_tick();
      pix_en = 1'b0;
      repeat (3) cyc();
      pix_en = 1'b1;
      cyc();
      pix_en = 1'b0;
      adv();
   endtask

   task automatic fast_tick();
      pix_en = 1'b1;
      cyc();
      pix_en = 1'b0;
      adv();
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_en = 1'b1; rst_s = 1'b1; pen_s = 1'b0;
      repeat (3) cyc();
      checks++;
      if (h_cnt !== 10'd799 || v_cnt !== 10'd524) begin
         failures++;
         $display("FAIL reset_pos: got (%0d,%0d) expected (799,524)", h_cnt, v_cnt);
      end
      checks++;
      if (video_on !== 1'b0) begin
         failures++;
         $display("FAIL reset_video_on: got %b expected 0", video_on);
      end
      checks++;
      if (hs !== 1'b1 || vs !== 1'b1) begin
         failures++;
         $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", hs, vs);
      end
      checks++;
      if (line_start !== 1'b0 || frame_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses: got ls=%b fs=%b expected 0 0", line_start, frame_start);
      end
      rst = 1'b0; pix_en = 1'b0;
      eh = 799; ev = 524;
   endtask

   task automatic test_first_pixel();
      pix_tick();
      checks++;
      if (h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
         failures++;
         $display("FAIL first_pos: got (%0d,%0d) expected (0,0)", h_cnt, v_cnt);
      end
      checks++;
      if (video_on !== 1'b1 || line_start !== 1'b1 || frame_start !== 1'b1) begin
         failures++;
         $display("FAIL first_flags: got vo=%b ls=%b fs=%b expected 1 1 1",
                  video_on, line_start, frame_start);
      end
      cyc();
      checks++;
      if (line_start !== 1'b0 || frame_start !== 1'b0 || h_cnt !== 10'd0) begin
         failures++;
         $display("FAIL first_pulse_len: got ls=%b fs=%b h=%0d expected 0 0 0",
                  line_start, frame_start, h_cnt);
      end
   endtask

   task automatic test_hsync();
      int   low = 0;
      logic exp_hs, exp_vo;
      for (int i = 0; i < 800; i++) begin
         pix_tick();
         exp_hs = (eh >= 656 && eh < 752) ? 1'b0 : 1'b1;
         exp_vo = (eh < 640 && ev < 480);
         checks++;
         if (h_cnt !== 10'(eh) || v_cnt !== 10'(ev)) begin
            failures++;
            $display("FAIL hsync_pos: got (%0d,%0d) expected (%0d,%0d)", h_cnt, v_cnt, eh, ev);
         end
         checks++;
         if (hs !== exp_hs) begin
            failures++;
            $display("FAIL hsync_level: h=%0d got hs=%b expected %b", eh, hs, exp_hs);
         end
         checks++;
         if (video_on !== exp_vo) begin
            failures++;
            $display("FAIL hsync_video_on: h=%0d got %b expected %b", eh, video_on, exp_vo);
         end
         if (hs === 1'b0) low++;
      end
      checks++;
      if (low != 96) begin
         failures++;
         $display("FAIL hsync_width: got %0d expected 96", low);
      end
      checks++;
      if (line_start !== 1'b1 || frame_start !== 1'b0 || v_cnt !== 10'd1) begin
         failures++;
         $display("FAIL hsync_wrap: got ls=%b fs=%b v=%0d expected 1 0 1",
                  line_start, frame_start, v_cnt);
      end
   endtask

   task automatic test_line_wrap();
      while (!(eh == 799 && ev == 10)) fast_tick();
      checks++;
      if (h_cnt !== 10'd799 || v_cnt !== 10'd10 || video_on !== 1'b0 || hs !== 1'b1) begin
         failures++;
         $display("FAIL wrap_pre: got (%0d,%0d) vo=%b hs=%b expected (799,10) 0 1",
                  h_cnt, v_cnt, video_on, hs);
      end
      fast_tick();
      checks++;
      if (h_cnt !== 10'd0 || v_cnt !== 10'd11) begin
         failures++;
         $display("FAIL wrap_pos: got (%0d,%0d) expected (0,11)", h_cnt, v_cnt);
      end
      checks++;
      if (line_start !== 1'b1 || frame_start !== 1'b0 || video_on !== 1'b1 || vs !== 1'b1) begin
         failures++;
         $display("FAIL wrap_flags: got ls=%b fs=%b vo=%b vs=%b expected 1 0 1 1",
                  line_start, frame_start, video_on, vs);
      end
      cyc();
      checks++;
      if (line_start !== 1'b0) begin
         failures++;
         $display("FAIL wrap_pulse_len: got ls=%b expected 0", line_start);
      end
   endtask

   task automatic test_hold_reset();
      logic [26:0] exp_vec;
      repeat (300) fast_tick();
      // (300,11): visible, no sync, no pulses
      exp_vec = {10'd300, 10'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 100; i++) begin
         cyc();
         checks++;
         if ({h_cnt, v_cnt, video_on, hs, vs, line_start, frame_start} !== exp_vec) begin
            failures++;
            $display("FAIL hold_stable: cycle %0d got (%0d,%0d) vo=%b hs=%b vs=%b ls=%b fs=%b expected (300,11) 1 1 1 0 0",
                     i, h_cnt, v_cnt, video_on, hs, vs, line_start, frame_start);
         end
      end
      rst = 1'b1; pix_en = 1'b1;
      cyc();
      checks++;
      if ({h_cnt, v_cnt, video_on, hs, vs, line_start, frame_start}
          !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL midframe_reset: got (%0d,%0d) vo=%b hs=%b vs=%b ls=%b fs=%b expected (799,524) 0 1 1 0 0",
                  h_cnt, v_cnt, video_on, hs, vs, line_start, frame_start);
      end
      rst = 1'b0; pix_en = 1'b0;
      eh = 799; ev = 524;
      pix_tick();
      checks++;
      if (h_cnt !== 10'd0 || v_cnt !== 10'd0 || frame_start !== 1'b1) begin
         failures++;
         $display("FAIL restart: got (%0d,%0d) fs=%b expected (0,0) 1", h_cnt, v_cnt, frame_start);
      end
   endtask

   task automatic test_full_frame();
      int   seen = 0, gap = 0, vs_low = 0;
      logic exp_hs, exp_vs, exp_vo;
      rst_s = 1'b1; pen_s = 1'b1;
      repeat (2) cyc();
      checks++;
      if (sh_cnt !== 5'd24 || sv_cnt !== 5'd18 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_vo !== 1'b0) begin
         failures++;
         $display("FAIL small_reset: got (%0d,%0d) hs=%b vs=%b vo=%b expected (24,18) 1 1 0",
                  sh_cnt, sv_cnt, s_hs, s_vs, s_vo);
      end
      rst_s = 1'b0;
      sh = 24; sv = 18;
      for (int i = 0; i < 950; i++) begin
         cyc();
         sadv();
         exp_hs = (sh >= 18 && sh < 22) ? 1'b0 : 1'b1;
         exp_vs = (sv >= 14 && sv < 16) ? 1'b0 : 1'b1;
         exp_vo = (sh < 16 && sv < 12);
         checks++;
         if ({sh_cnt, sv_cnt, s_hs, s_vs, s_vo, s_ls, s_fs} !==
             {5'(sh), 5'(sv), exp_hs, exp_vs, exp_vo, 1'(sh == 0), 1'(sh == 0 && sv == 0)}) begin
            failures++;
            $display("FAIL frame_outputs: got (%0d,%0d) hs=%b vs=%b vo=%b ls=%b fs=%b expected (%0d,%0d) %b %b %b %b %b",
                     sh_cnt, sv_cnt, s_hs, s_vs, s_vo, s_ls, s_fs,
                     sh, sv, exp_hs, exp_vs, exp_vo, sh == 0, sh == 0 && sv == 0);
         end
         if (s_vs === 1'b0) vs_low++;
         gap++;
         if (s_fs === 1'b1) begin
            if (seen > 0) begin
               checks++;
               if (gap != 475) begin
                  failures++;
                  $display("FAIL frame_period: got %0d expected 475", gap);
               end
            end
            gap = 0;
            seen++;
         end
      end
      checks++;
      if (seen != 2) begin
         failures++;
         $display("FAIL frame_start_count: got %0d expected 2", seen);
      end
      checks++;
      if (vs_low != 100) begin
         failures++;
         $display("FAIL vsync_width: got %0d expected 100", vs_low);
      end
   endtask

   task automatic test_sync_pol();
      int   hs_hi = 0, vs_hi = 0;
      logic exp_hs, exp_vs, exp_vo;
      rst_s = 1'b1; pen_s = 1'b1;
      repeat (2) cyc();
      checks++;
      if (p_hs !== 1'b0 || p_vs !== 1'b0 || ph_cnt !== 5'd24 || pv_cnt !== 5'd18) begin
         failures++;
         $display("FAIL pol_reset: got hs=%b vs=%b (%0d,%0d) expected 0 0 (24,18)",
                  p_hs, p_vs, ph_cnt, pv_cnt);
      end
      rst_s = 1'b0;
      sh = 24; sv = 18;
      for (int i = 0; i < 475; i++) begin
         cyc();
         sadv();
         exp_hs = (sh >= 18 && sh < 22);
         exp_vs = (sv >= 14 && sv < 16);
         exp_vo = (sh < 16 && sv < 12);
         checks++;
         if ({ph_cnt, pv_cnt, p_hs, p_vs, p_vo, p_ls, p_fs} !==
             {5'(sh), 5'(sv), exp_hs, exp_vs, exp_vo, 1'(sh == 0), 1'(sh == 0 && sv == 0)}) begin
            failures++;
            $display("FAIL pol_outputs: got (%0d,%0d) hs=%b vs=%b vo=%b ls=%b fs=%b expected (%0d,%0d) %b %b %b",
                     ph_cnt, pv_cnt, p_hs, p_vs, p_vo, p_ls, p_fs, sh, sv, exp_hs, exp_vs, exp_vo);
         end
         if (p_hs === 1'b1) hs_hi++;
         if (p_vs === 1'b1) vs_hi++;
      end
      checks++;
      if (hs_hi != 76 || vs_hi != 50) begin
         failures++;
         $display("FAIL pol_widths: got hs=%0d vs=%0d expected 76 50", hs_hi, vs_hi);
      end
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_hsync();
      test_line_wrap();
      test_hold_reset();
      test_full_frame();
      test_sync_pol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
